// File: rtl/bf16_dot_seq.sv
// Sequencer for a bf16 dot product built on one shared combinational bf16_fma.
// Accumulates one element pair per cycle; the final result is published on DONE exit.
module bf16_dot_seq #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic [15:0]      init_acc,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic [15:0]      fma_a,
  output logic [15:0]      fma_b,
  output logic [15:0]      fma_c,
  input  logic [15:0]      fma_result,
  input  logic [3:0]       fma_flags,
  output logic             busy,
  output logic             done,
  output logic [15:0]      result,
  output logic [3:0]       flags,
  output logic [LEN_W-1:0] remaining
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [15:0]      acc;
  logic [3:0]       wflags;
  logic [LEN_W-1:0] rem;
  logic             accept;
  logic             last_elem;

  // The FMA sees the current pair and running accumulator at all times.
  assign fma_a = in_a;
  assign fma_b = in_b;
  assign fma_c = acc;

  assign in_ready  = (state == S_RUN) && !abort;
  assign accept    = in_ready && in_valid;
  assign last_elem = (rem == LEN_W'(1));

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign remaining = rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = (length == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Abort wins over a same-cycle accept.
        if (abort) begin
          state_nx = S_IDLE;
        end else if (accept && last_elem) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= 16'h0000;
      wflags <= 4'h0;
      rem    <= '0;
      result <= 16'h0000;
      flags  <= 4'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc    <= init_acc;
            wflags <= 4'h0;
            rem    <= length;
          end
        end
        S_RUN: begin
          if (abort) begin
            rem <= '0;
          end else if (accept) begin
            acc    <= fma_result;
            wflags <= wflags | fma_flags;
            rem    <= rem - LEN_W'(1);
          end
        end
        S_DONE: begin
          result <= acc;
          flags  <= wflags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bf16_dot_seq.md
BF16_DOT_SEQ -- requirements
Module: bf16_dot_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of the element-count field.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new dot-product job; sampled only in IDLE.
REQ-005 SHALL have port length  input  LEN_W  number of element pairs in the job; sampled with start.
REQ-006 SHALL have port init_acc  input  16  bf16 initial accumulator value; sampled with start.
REQ-007 SHALL have port abort  input  1  cancel the running job.
REQ-008 SHALL have port in_valid  input  1  element pair valid.
REQ-009 SHALL have port in_ready  output  1  sequencer accepts an element pair this cycle.
REQ-010 SHALL have ports in_a, in_b  input  16 each  bf16 element operands.
REQ-011 SHALL have ports fma_a, fma_b, fma_c  output  16 each  operands to the shared combinational bf16_fma.
REQ-012 SHALL have port fma_result  input  16  bf16_fma result.
REQ-013 SHALL have port fma_flags  input  4  bf16_fma flags {invalid, overflow, underflow, inexact}.
REQ-014 SHALL have port busy  output  1  high in RUN and DONE.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port result  output  16  final accumulator, held until the next job completes.
REQ-017 SHALL have port flags  output  4  sticky OR of fma_flags over the last completed job.
REQ-018 SHALL have port remaining  output  LEN_W  element pairs still to be accepted.

Function
REQ-019 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-020 IDLE, start=1, length!=0: SHALL load acc=init_acc and remaining=length, clear the working flags, and go to RUN.
REQ-021 IDLE, start=1, length==0: SHALL load acc=init_acc, clear the working flags, and go to DONE with no FMA use.
REQ-022 SHALL ignore start outside IDLE.
REQ-023 in_ready SHALL be 1 only in RUN with abort=0; an element is accepted on a cycle where in_valid & in_ready.
REQ-024 SHALL drive fma_a=in_a, fma_b=in_b and fma_c=acc combinationally at all times.
REQ-025 On accept: acc<=fma_result, working flags |= fma_flags, remaining<=remaining-1 (single cycle per element, zero added latency).
REQ-026 On accept with remaining==1: SHALL go to DONE next cycle.
REQ-027 A RUN cycle with in_valid=0 SHALL change no state.
REQ-028 In DONE: done=1 for exactly one cycle, result<=acc and flags<=working flags on that edge (visible from the next cycle), then go to IDLE.
REQ-029 result and flags SHALL change only on DONE exit or reset.
REQ-030 abort=1 in RUN SHALL return to IDLE next cycle with no done pulse; result, flags unchanged; remaining<=0.
REQ-031 abort SHALL have priority over an element accept in the same cycle; abort in IDLE or DONE SHALL be ignored.
REQ-032 busy SHALL be 1 in RUN and DONE, 0 in IDLE; a new start is accepted at the earliest in the cycle after done.
REQ-033 Throughput SHALL be 1 element/cycle; job latency = length accepted elements + 1 DONE cycle.

Reset
REQ-034 reset=1 SHALL force, at the next edge: state=IDLE, acc=0, remaining=0, working flags=0, result=16'h0000, flags=4'h0, done=0, in_ready=0, busy=0.
REQ-035 reset SHALL override start, abort and in_valid; reset mid-job discards the job with no done pulse.

Verification
REQ-036 Bench: bf16_fma replaced by a stub driving fma_result/fma_flags; init 3F80, length=2, pairs (3F80,4000),(4000,4040); stub returns 4040 then 4110 -> fma_c=3F80 then 4040; one done pulse; result=4110; flags=0.
REQ-037 Same job with in_valid low for 3 cycles between pairs -> no state change during gaps; result=4110; done exactly once.
REQ-038 length=0, init_acc=4040 -> done on the 2nd cycle after start; result=4040; flags=0; in_ready never high.
REQ-039 length=3, stub flags 4'b0001 on element 1, 4'b0100 on element 3 -> flags=4'b0101 after done.
REQ-040 abort together with in_valid on element 2 of 4 -> element not accepted; IDLE next cycle; no done; result/flags keep previous-job values; start during RUN ignored.
REQ-041 reset asserted mid-RUN -> all outputs at reset values next cycle; subsequent job completes normally.
